// File: rtl/cosa_pkg.sv
// -----------------------------------------------------------------------------
// cosa_pkg
// Shared constants and helpers for the pipelined conditional-sum adder.
//   COSA_WIDTH  default operand/result width
//   COSA_BLOCK  default slice width resolved per pipeline stage
//   cosaStages  pipeline depth for a WIDTH/BLOCK pair; an illegal pair returns 1
//               so elaboration still reaches the configuration check in the top
// -----------------------------------------------------------------------------
package cosa_pkg;

  localparam int COSA_WIDTH = 32;
  localparam int COSA_BLOCK = 8;

  // An unusable configuration maps to a single stage so array bounds stay sane
  // while the top-level check reports the real problem.
  function automatic int cosaStages(input int width, input int block);
    if (block < 1) return 1;
    if ((width % block) != 0) return 1;
    return width / block;
  endfunction

endpackage

// File: rtl/cosa_slice.sv
// -----------------------------------------------------------------------------
// cosa_slice
// Combinational BLOCK-bit conditional-sum cell. Both carry-in hypotheses are
// summed in parallel and the incoming carry only drives the final select.
// Ports:
//   i_a, i_b     BLOCK-bit operand slices
//   i_carrySel   carry from the previous slice (selects sum-with-carry)
//   o_sum        selected BLOCK-bit slice sum
//   o_carry      carry out of this slice
// -----------------------------------------------------------------------------
module cosa_slice #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_carrySel,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_carry
);

  logic [BLOCK:0] w_sum0;
  logic [BLOCK:0] w_sum1;

  assign w_sum0 = {1'b0, i_a} + {1'b0, i_b};
  assign w_sum1 = {1'b0, i_a} + {1'b0, i_b} + {{BLOCK{1'b0}}, 1'b1};

  assign {o_carry, o_sum} = i_carrySel ? w_sum1 : w_sum0;

endmodule

// File: rtl/pipelined_cond_sum_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cond_sum_adder
// Pipelined conditional-sum adder/subtractor. One BLOCK-bit slice is resolved
// per stage, LSB slice first, so latency equals STAGES = WIDTH/BLOCK cycles.
// A valid/ready handshake with a global stall gives full backpressure.
// Optional build macro: COSUA_OVERFLOW_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake
//   a, b                WIDTH-bit operands
//   cin                 carry-in (ignored when sub=1)
//   sub                 0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid/out_ready result handshake
//   sum, cout           result modulo 2^WIDTH and MSB carry-out
//   ovf                 (COSUA_OVERFLOW_EN only) two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_cond_sum_adder
  import cosa_pkg::*;
#(
  parameter int WIDTH = COSA_WIDTH,
  parameter int BLOCK = COSA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef COSUA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = cosaStages(WIDTH, BLOCK);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_badConfig
    $error("pipelined_cond_sum_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 1");
  end

  // Per-stage registers. r_a/r_b are skew registers carrying the operand
  // slices not yet consumed; r_sum accumulates the resolved low slices.
  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0]            r_carry;
  logic [STAGES-1:0][WIDTH-1:0] r_sum;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;

  logic             w_stall;
  logic [WIDTH-1:0] w_bEff;
  logic             w_c0;

  logic [STAGES-1:0][BLOCK-1:0] w_sliceA;
  logic [STAGES-1:0][BLOCK-1:0] w_sliceB;
  logic [STAGES-1:0][BLOCK-1:0] w_sliceSum;
  logic [STAGES-1:0]            w_sliceCin;
  logic [STAGES-1:0]            w_sliceCarry;

  // Only a result that cannot leave blocks the pipe; bubbles never stall it.
  assign w_stall  = r_valid[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;

  // Subtraction is a+~b+1, so the +1 rides in as the stage-0 carry.
  assign w_bEff = sub ? ~b : b;
  assign w_c0   = sub | cin;

  // Stage 0 takes its slice straight from the ports; later stages pick their
  // slice out of the previous stage's skew registers.
  always_comb begin
    w_sliceA      = '0;
    w_sliceB      = '0;
    w_sliceCin    = '0;
    w_sliceA[0]   = a[BLOCK-1:0];
    w_sliceB[0]   = w_bEff[BLOCK-1:0];
    w_sliceCin[0] = w_c0;
    for (int k = 1; k < STAGES; k++) begin
      w_sliceA[k]   = r_a[k-1][k*BLOCK +: BLOCK];
      w_sliceB[k]   = r_b[k-1][k*BLOCK +: BLOCK];
      w_sliceCin[k] = r_carry[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cosa_slice #(.BLOCK(BLOCK)) u_slice (
      .i_a        (w_sliceA[k]),
      .i_b        (w_sliceB[k]),
      .i_carrySel (w_sliceCin[k]),
      .o_sum      (w_sliceSum[k]),
      .o_carry    (w_sliceCarry[k])
    );
  end

  // Whole pipeline advances together or holds together. Each stage ORs its
  // slice into the partial sum; upper bits are zero until their stage runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (!w_stall) begin
      r_valid[0] <= in_valid;
      r_a[0]     <= a;
      r_b[0]     <= w_bEff;
      r_carry[0] <= w_sliceCarry[0];
      r_sum[0]   <= WIDTH'(w_sliceSum[0]);
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_a[k]     <= r_a[k-1];
        r_b[k]     <= r_b[k-1];
        r_carry[k] <= w_sliceCarry[k];
        r_sum[k]   <= r_sum[k-1] | (WIDTH'(w_sliceSum[k]) << (k*BLOCK));
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_carry[STAGES-1];

`ifdef COSUA_OVERFLOW_EN
  logic w_msbCarryIn;
  logic r_ovf;

  // Carry into the MSB is recovered from the MSB sum bit of the last slice.
  assign w_msbCarryIn = w_sliceA[STAGES-1][BLOCK-1] ^ w_sliceB[STAGES-1][BLOCK-1]
                      ^ w_sliceSum[STAGES-1][BLOCK-1];

  // Registered with the last stage so it shares its latency and stall hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_ovf <= w_msbCarryIn ^ w_sliceCarry[STAGES-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
